// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*XLEN work register, with sign handling wrapped around an unsigned core.
module alu_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            isALUreg,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic            kill,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            isMulDiv,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              N        = XLEN / UNROLL;
  localparam int              CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(N - 1);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  // Handshake: start is a request taken only in IDLE (no queueing, kill drops it);
  // busy stays high from the accept edge until the result edge; done is a one-cycle
  // pulse marking result valid, and result then holds until the next done.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [2:0]          op;
  logic                a_neg, b_neg, special;
  logic [XLEN-1:0]     opnd;
  logic [2*XLEN-1:0]   work, work_step;
  logic [CW-1:0]       cnt;

  logic                accept;
  logic                sign_a, sign_b, in_a_neg, in_b_neg;
  logic [XLEN-1:0]     in_a_abs, in_b_abs;
  logic                div_zero, div_ovf, fast;
  logic [XLEN-1:0]     fast_val;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem, fin_val;

  assign isMulDiv = isALUreg && (funct7 == 7'b0000001);
  assign accept   = (state == S_IDLE) && start && isMulDiv && !kill;

  // Operand conditioning and the divide corner cases that skip the iteration.
  always_comb begin
    sign_a   = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    sign_b   = sign_a && (funct3 != 3'b010);
    in_a_neg = sign_a && rs1[XLEN-1];
    in_b_neg = sign_b && rs2[XLEN-1];
    in_a_abs = in_a_neg ? -rs1 : rs1;
    in_b_abs = in_b_neg ? -rs2 : rs2;
    div_zero = funct3[2] && (rs2 == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs1 == MIN_VAL) && (rs2 == '1);
    fast     = div_zero || div_ovf;
    fast_val = rs1;
    if (div_zero) fast_val = funct3[1] ? rs1 : '1;
    else          fast_val = funct3[1] ? '0 : rs1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = fast ? S_FINISH : S_CALC;
      S_CALC: begin
        if (kill)              state_next = S_IDLE;
        else if (cnt == '0)    state_next = S_FINISH;
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // Multiply keeps {hi_acc, multiplier} and shifts right; divide keeps
  // {remainder, dividend/quotient} and shifts left.
  always_comb begin
    logic [2*XLEN-1:0] w;
    logic [XLEN:0]     sum, rsh, diff;
    w    = work;
    sum  = '0;
    rsh  = '0;
    diff = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (!op[2]) begin
        sum = {1'b0, w[2*XLEN-1:XLEN]} + (w[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        w   = {sum, w[XLEN-1:1]};
      end else begin
        rsh  = {w[2*XLEN-1:XLEN], w[XLEN-1]};
        diff = rsh - {1'b0, opnd};
        w    = diff[XLEN] ? {rsh[XLEN-1:0], w[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], w[XLEN-2:0], 1'b1};
      end
    end
    work_step = w;
  end

  always_comb begin
    prod    = (a_neg ^ b_neg) ? -work : work;
    quo     = (a_neg ^ b_neg) ? -work[XLEN-1:0] : work[XLEN-1:0];
    rem     = a_neg ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
    fin_val = rem;
    case (op)
      3'b000:                 fin_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_val = quo;
      default:                fin_val = rem;
    endcase
    if (special) fin_val = work[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op      <= '0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      special <= 1'b0;
      opnd    <= '0;
      work    <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op      <= funct3;
            a_neg   <= in_a_neg;
            b_neg   <= in_b_neg;
            special <= fast;
            cnt     <= CNT_INIT;
            opnd    <= funct3[2] ? in_b_abs : in_a_abs;
            // The fast path parks its final answer in the low half of work.
            if (fast) work <= {{XLEN{1'b0}}, fast_val};
            else      work <= {{XLEN{1'b0}}, (funct3[2] ? in_a_abs : in_b_abs)};
          end
        end
        S_CALC: begin
          work <= work_step;
          cnt  <= cnt - CW'(1);
        end
        S_FINISH: begin
          if (!kill) begin
            result <= fin_val;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Parametrised successor to the combinational ALU decoder, adding the RV32M multiply/divide instruction group.
- Decodes funct3/funct7 of an R-type M-extension instruction.
- Executes it on an iterative shift-add multiplier / restoring divider with a start/busy/done handshake.
- Sits beside the single-cycle ALU; the control unit stalls the core while busy=1 and writes result to rd when done=1.

Parameters:
- XLEN, 32, operand/result width; must be ≥8 and even.
- UNROLL, 1, bits processed per CALC cycle; must divide XLEN; N = XLEN/UNROLL iteration cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- isALUreg  input  1  instruction is R-type OP.
- funct7  input  7  instruction funct7; operation is M-group only when funct7==7'b0000001.
- funct3  input  3  selects mul/mulh/mulhsu/mulhu/div/divu/rem/remu (000..111).
- kill  input  1  abort in-flight operation (pipeline flush).
- rs1  input  XLEN  operand A (dividend/multiplicand).
- rs2  input  XLEN  operand B (divisor/multiplier).
- isMulDiv  output  1  combinational: isALUreg && funct7==7'b0000001.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result, held until next done.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, result=0; internal accumulators cleared.
  - Reset takes priority over every other input, including mid-operation.
- States: IDLE, CALC, FINISH.
- IDLE:
  - start && isMulDiv at an edge (accept edge, E0) latches funct3, rs1 and rs2.
  - Operands are latched as absolute values plus sign flags, per signedness:
    - mul, mulh, div, rem: both operands signed.
    - mulhsu: rs1 signed, rs2 unsigned.
    - mulhu, divu, remu: both unsigned.
  - The next state is FINISH for the special-case divide conditions listed below; otherwise it is CALC.
  - start with isMulDiv=0 is ignored.
- CALC:
  - Runs N cycles; a counter counts N-1 down to 0. Each cycle processes UNROLL bits.
  - Multiply: 2*XLEN unsigned product, shift-add, LSB-first on the multiplier.
  - Divide: restoring, MSB-first, producing quotient and remainder.
  - When counter==0, go to FINISH.
- FINISH (one cycle):
  - Apply sign correction.
  - Product: negated if the sign flags differ (mul/mulh/mulhsu).
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the dividend's sign.
  - Select the output:
    - mul: low XLEN bits.
    - mulh/mulhsu/mulhu: high XLEN bits.
    - div/divu: quotient.
    - rem/remu: remainder.
  - At the exit edge, result is registered, done=1 for exactly one cycle, state=IDLE.
- Latency:
  - Normal: done is high in the cycle following edge E0+N+1; for XLEN=32, UNROLL=1 that is 34 clocks from accept.
  - Special case: done is high after edge E0+1.
- Special cases (fast path, no CALC):
  - Divide by zero (rs2==0):
    - div/divu: quotient = all ones.
    - rem/remu: remainder = rs1.
  - Signed overflow (div/rem, rs1 == 1<<(XLEN-1), rs2 == all ones):
    - div: quotient = rs1.
    - rem: remainder = 0.
  - Multiply has no special cases.
- busy=1 in CALC and FINISH; busy=0 in the cycle in which done=1.
- start while busy is ignored and not queued; start in the same cycle done=1 is accepted (back-to-back).
- kill=1 while busy: next state=IDLE, no done pulse, result unchanged.
  - kill in IDLE has no effect; kill together with start in IDLE means the start is dropped.
- Operand inputs may change after E0 without affecting the in-flight operation.
- All arithmetic is modulo 2^XLEN on outputs; no X propagation from unused latched fields.

Test Plan:
- Reset mid-CALC (rst_n=0 at the 10th cycle after a div start) -> busy=0, done=0, result=0 on the next cycle; a fresh start then behaves normally.
- mul rs1=0xFFFFFFFF (-1), rs2=7 -> done after 34 clocks, result=0xFFFFFFF9. mulh with the same operands -> 0xFFFFFFFF. mulhu -> 0x00000006. mulhsu -> 0xFFFFFFFF.
- div rs1=-7 (0xFFFFFFF9), rs2=2 -> result=0xFFFFFFFD (-3); rem with the same operands -> 0xFFFFFFFF (-1). divu 100/7 -> 14; remu 100/7 -> 2.
- divu rs2=0, rs1=0x1234 -> done 2 clocks after accept, result=0xFFFFFFFF. remu with the same operands -> 0x1234. div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem with the same operands -> 0.
- kill asserted 5 cycles into a mul -> no done pulse, result keeps its previous value. A start while busy is ignored. A start in the done cycle gives a second done exactly 34 clocks later.
- Parameter sweep XLEN=16, UNROLL=4: mul 0x1234*0x0010 -> 0x2340 after N+2 = 6 clocks; start with funct7=0x20 -> isMulDiv=0, no busy.
